// File: rtl/spi_shift_reg.sv
// Double-buffered serial shift register: parallel words in via valid/ready, shifted
// out one bit per shift_en strobe while receive bits shift in; received words come back in parallel.
module spi_shift_reg #(
  parameter int   WIDTH     = 8,
  parameter int   LSB_FIRST = 0,
  parameter logic IDLE_OUT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic             state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] sr_shifted;

  assign sr_shifted = (LSB_FIRST != 0) ? {ser_in, sr_q[WIDTH-1:1]}
                                       : {sr_q[WIDTH-2:0], ser_in};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;

    // Accept and transfer are disjoint: a write only lands when the buffer is empty.
    if (wr_valid && !hold_full_q) begin
      hold_d      = wr_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          sr_d        = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_SHIFT;
        end
      end
      default: begin
        if (shift_en) begin
          sr_d  = sr_shifted;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            rd_data_d  = sr_shifted;
            rd_valid_d = 1'b1;
            cnt_d      = cnt_q;
            if (hold_full_q) begin
              // Chain straight into the queued word with no idle gap.
              sr_d        = hold_q;
              hold_full_d = 1'b0;
              cnt_d       = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign wr_ready = !hold_full_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ser_out  = busy ? ((LSB_FIRST != 0) ? sr_q[0] : sr_q[WIDTH-1]) : IDLE_OUT;

endmodule

// File: tb/tb_spi_shift_reg.sv
// Directed bench for spi_shift_reg: MSB-first W8, LSB-first W8 and W2 instances share
// clock, reset, strobe and serial input; each gets its own write valid.
module tb_spi_shift_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] wr_data;
  logic [2:0] wv;
  logic       shift_en, ser_in;

  logic       a_wr_ready, a_ser_out, a_rd_valid, a_busy;
  logic [7:0] a_rd_data;
  logic       b_wr_ready, b_ser_out, b_rd_valid, b_busy;
  logic [7:0] b_rd_data;
  logic       c_wr_ready, c_ser_out, c_rd_valid, c_busy;
  logic [1:0] c_rd_data;

  spi_shift_reg #(.WIDTH(8), .LSB_FIRST(0), .IDLE_OUT(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wv[0]), .wr_ready(a_wr_ready),
    .shift_en(shift_en), .ser_in(ser_in), .ser_out(a_ser_out), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .busy(a_busy));

  spi_shift_reg #(.WIDTH(8), .LSB_FIRST(1), .IDLE_OUT(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wv[1]), .wr_ready(b_wr_ready),
    .shift_en(shift_en), .ser_in(ser_in), .ser_out(b_ser_out), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .busy(b_busy));

  spi_shift_reg #(.WIDTH(2), .LSB_FIRST(0), .IDLE_OUT(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data[1:0]), .wr_valid(wv[2]), .wr_ready(c_wr_ready),
    .shift_en(shift_en), .ser_in(ser_in), .ser_out(c_ser_out), .rd_data(c_rd_data),
    .rd_valid(c_rd_valid), .busy(c_busy));

  int checks = 0, failures = 0;
  int pa = 0, pb = 0, pc = 0;

  always @(negedge clk) begin
    if (a_rd_valid) pa++;
    if (b_rd_valid) pb++;
    if (c_rd_valid) pc++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int gap, input logic si);
    repeat (gap) tick();
    ser_in   = si;
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] d);
    wr_data = d;
    wv      = sel;
    tick();
    wv      = 3'b000;
  endtask

  logic [7:0] seq;

  initial begin
    rst_n = 1'b0; wr_data = '0; wv = '0; shift_en = 1'b0; ser_in = 1'b0;
    #22 rst_n = 1'b1;
    tick();

    // reset values
    chk("rst_wr_ready", a_wr_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_ser_out", a_ser_out, 1);
    chk("rst_rd_data", a_rd_data, 0);
    chk("rst_rd_valid", a_rd_valid, 0);
    chk("rst_c_ser_out", c_ser_out, 0);

    // single word, MSB first, looped back
    wr(3'b001, 8'hA5);
    chk("w_wr_ready_low", a_wr_ready, 0);
    chk("w_busy_low", a_busy, 0);
    tick();
    chk("w_busy_high", a_busy, 1);
    chk("w_wr_ready_high", a_wr_ready, 1);
    for (int i = 0; i < 8; i++) begin
      seq = {seq[6:0], a_ser_out};
      strobe(0, a_ser_out);
    end
    chk("s2_seq", seq, 8'hA5);
    chk("s2_rd_data", a_rd_data, 8'hA5);
    chk("s2_rd_valid", a_rd_valid, 1);
    chk("s2_busy", a_busy, 0);
    tick();
    chk("s2_rd_valid_pulse", a_rd_valid, 0);
    chk("s2_pulses", pa, 1);

    // reset mid-word
    wr(3'b001, 8'h5A);
    tick();
    for (int i = 0; i < 3; i++) strobe(0, a_ser_out);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_busy", a_busy, 0);
    chk("mr_wr_ready", a_wr_ready, 1);
    chk("mr_ser_out", a_ser_out, 1);
    chk("mr_rd_data", a_rd_data, 0);
    chk("mr_rd_valid", a_rd_valid, 0);
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) strobe(0, a_ser_out);
    chk("mr_busy_after", a_busy, 0);
    chk("mr_no_pulse", pa, 1);

    // back-to-back words
    wr(3'b001, 8'h3C);
    tick();
    chk("bb_busy", a_busy, 1);
    wr(3'b001, 8'hC3);
    chk("bb_wr_ready_low", a_wr_ready, 0);
    for (int i = 0; i < 16; i++) begin
      strobe(0, a_ser_out);
      if (i == 6) chk("bb_hold_full", a_wr_ready, 0);
      if (i == 7) begin
        chk("bb_rv1", a_rd_valid, 1);
        chk("bb_rd1", a_rd_data, 8'h3C);
        chk("bb_busy_stay", a_busy, 1);
        chk("bb_wr_ready_back", a_wr_ready, 1);
        chk("bb_ser_out2", a_ser_out, 1);
      end
      if (i == 14) chk("bb_rv_gap", a_rd_valid, 0);
      if (i == 15) begin
        chk("bb_rv2", a_rd_valid, 1);
        chk("bb_rd2", a_rd_data, 8'hC3);
        chk("bb_busy_end", a_busy, 0);
      end
    end
    tick();
    chk("bb_pulses", pa, 3);

    // gapped strobes, stray strobes in IDLE including accept and load edges
    strobe(2, 1'b1);
    strobe(2, 1'b0);
    chk("g_idle_busy", a_busy, 0);
    chk("g_idle_ser_out", a_ser_out, 1);
    chk("g_idle_pulses", pa, 3);
    shift_en = 1'b1;
    wr(3'b001, 8'hA5);
    tick();
    shift_en = 1'b0;
    chk("g_busy", a_busy, 1);
    chk("g_first_bit", a_ser_out, 1);
    for (int i = 0; i < 8; i++) begin
      seq = {seq[6:0], a_ser_out};
      strobe(4, a_ser_out);
    end
    chk("g_seq", seq, 8'hA5);
    chk("g_rd_data", a_rd_data, 8'hA5);
    chk("g_rd_valid", a_rd_valid, 1);
    chk("g_busy_end", a_busy, 0);
    tick();
    chk("g_pulses", pa, 4);

    // LSB first, ser_in held high
    wr(3'b010, 8'h01);
    tick();
    for (int i = 0; i < 8; i++) begin
      seq[i] = b_ser_out;
      strobe(0, 1'b1);
    end
    chk("l_seq", seq, 8'h01);
    chk("l_rd_data", b_rd_data, 8'hFF);
    chk("l_rd_valid", b_rd_valid, 1);
    chk("l_busy", b_busy, 0);
    tick();
    chk("l_ser_out_idle", b_ser_out, 1);
    chk("l_pulses", pb, 1);
    chk("l_a_untouched", pa, 4);

    // WIDTH=2 corner
    wr(3'b100, 8'h02);
    tick();
    chk("c_busy", c_busy, 1);
    chk("c_bit0", c_ser_out, 1);
    strobe(0, 1'b0);
    chk("c_bit1", c_ser_out, 0);
    chk("c_busy_mid", c_busy, 1);
    chk("c_rv_mid", c_rd_valid, 0);
    strobe(0, 1'b0);
    chk("c_rv", c_rd_valid, 1);
    chk("c_rd_data", c_rd_data, 2'b00);
    chk("c_busy_end", c_busy, 0);
    chk("c_idle_out", c_ser_out, 0);
    wr(3'b100, 8'h01);
    tick();
    chk("c2_bit0", c_ser_out, 0);
    strobe(0, 1'b1);
    chk("c2_bit1", c_ser_out, 1);
    strobe(0, 1'b1);
    chk("c2_rv", c_rd_valid, 1);
    chk("c2_rd_data", c_rd_data, 2'b11);
    tick();
    chk("c_pulses", pc, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
